// File: rtl/mips_pkg.sv
// mips_pkg: shared constants for the instruction feeder (NOP word, opcodes, issue FSM encoding).
`default_nettype none

package mips_pkg;

  localparam logic [31:0] NOP    = 32'h0000_0000;

  localparam logic [5:0]  OP_ADD = 6'b000001;
  localparam logic [5:0]  OP_LW  = 6'b000010;
  localparam logic [5:0]  OP_SW  = 6'b000100;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } feeder_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x WIDTH first-word-fall-through FIFO with flush and occupancy output.
// Revision 1.0
`default_nettype none

module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  // Flush dominates: nothing enters or leaves in a flush cycle.
  assign do_push = push & ~flush & (level_q != LW'(DEPTH));
  assign do_pop  = pop  & ~flush & (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;

endmodule

`default_nettype wire

// File: rtl/instr_feeder.sv
// instr_feeder: queues host instruction words and presents each on In for HOLD_CYCLES cycles.
// Optional single-step gating with INSTR_FEEDER_STEP_EN. Revision 1.0
`default_nettype none

module instr_feeder
  import mips_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 5,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [31:0]             wr_data,
  output logic                    wr_ready,
  input  logic                    flush,
  input  logic                    step,
  output logic [31:0]             In,
  output logic                    instr_valid,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  level,
  output logic [CNT_W-1:0]        issued_cnt
);

  localparam int          LVL_W      = $clog2(DEPTH) + 1;
  localparam int          HC_W       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);

  feeder_state_e    state_q, state_d;
  logic [31:0]      in_q, in_d;
  logic             valid_q, valid_d;
  logic [HC_W-1:0]  hcnt_q, hcnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             push, pop, step_ok, hold_done, can_issue;
  logic [31:0]      head_word;
  logic [LVL_W-1:0] fifo_level;

`ifdef INSTR_FEEDER_STEP_EN
  assign step_ok = step;
`else
  logic unused_step;
  assign unused_step = step;
  assign step_ok     = 1'b1;
`endif

  assign wr_ready = reset & ~flush & (fifo_level < LVL_W'(DEPTH));
  assign push     = wr_valid & wr_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head_word),
    .flush     (flush),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      in_q    <= NOP;
      valid_q <= 1'b0;
      hcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      valid_q <= valid_d;
      hcnt_q  <= hcnt_d;
      cnt_q   <= cnt_d;
    end
  end

  // A pop happens from IDLE or at the end of a hold, whenever a word waits.
  always_comb begin
    hold_done = (hcnt_q == '0);
    can_issue = (fifo_level != '0) & step_ok & ~flush;
    pop       = can_issue & ((state_q == IDLE) | hold_done);
    state_d   = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (pop) state_d = HOLD;
        HOLD:    if (hold_done && !pop) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_d    = in_q;
    valid_d = 1'b0;
    hcnt_d  = hcnt_q;
    cnt_d   = cnt_q;
    if (flush) begin
      in_d   = NOP;
      hcnt_d = '0;
    end else if (pop) begin
      in_d    = head_word;
      valid_d = 1'b1;
      hcnt_d  = HOLD_RELOAD;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if (state_q == HOLD) begin
      if (!hold_done) hcnt_d = hcnt_q - HC_W'(1);
      else            in_d   = NOP;
    end
  end

  assign In          = in_q;
  assign instr_valid = valid_q;
  assign busy        = (state_q == HOLD);
  assign level       = fifo_level;
  assign issued_cnt  = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_feeder.sv
// tb_instr_feeder: scoreboard bench for instr_feeder (HOLD=5 main instance, HOLD=1 / CNT_W=2 second instance).
`default_nettype none

module tb_instr_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid_a, flush_a, step_a;
  logic [31:0] wr_data_a;
  logic        wr_ready_a, instr_valid_a, busy_a;
  logic [31:0] in_a;
  logic [3:0]  level_a;
  logic [15:0] issued_a;

  logic        wr_valid_b, flush_b, step_b;
  logic [31:0] wr_data_b;
  logic        wr_ready_b, instr_valid_b, busy_b;
  logic [31:0] in_b;
  logic [3:0]  level_b;
  logic [1:0]  issued_b;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [15:0] model_cnt = '0;

  always #5 clk = ~clk;

  instr_feeder #(.DEPTH(8), .HOLD_CYCLES(5), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_a), .wr_data(wr_data_a),
    .wr_ready(wr_ready_a), .flush(flush_a), .step(step_a), .In(in_a),
    .instr_valid(instr_valid_a), .busy(busy_a), .level(level_a), .issued_cnt(issued_a)
  );

  instr_feeder #(.DEPTH(8), .HOLD_CYCLES(1), .CNT_W(2)) u_dut_b2b (
    .clk(clk), .reset(reset), .wr_valid(wr_valid_b), .wr_data(wr_data_b),
    .wr_ready(wr_ready_b), .flush(flush_b), .step(step_b), .In(in_b),
    .instr_valid(instr_valid_b), .busy(busy_b), .level(level_b), .issued_cnt(issued_b)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the main instance: accepted words in, issued words out.
  always @(negedge clk) begin
    if (!reset) begin
      sb_q.delete();
      model_cnt = '0;
    end else begin
      if (instr_valid_a) begin
        if (sb_q.size() == 0) begin
          check_val("sb_underflow", 64'(sb_q.size()), 64'd1);
        end else begin
          check_val("sb_in", 64'(in_a), 64'(sb_q.pop_front()));
        end
        model_cnt = model_cnt + 16'd1;
        check_val("sb_issued_cnt", 64'(issued_a), 64'(model_cnt));
      end
      if (flush_a) sb_q.delete();
      else if (wr_valid_a && wr_ready_a) sb_q.push_back(wr_data_a);
    end
  end

  initial begin
    int stalls;
    int guard;
    logic [15:0] cnt_before;

    reset = 1'b0; wr_valid_a = 1'b1; wr_data_a = 32'hDEAD_BEEF; flush_a = 1'b0; step_a = 1'b1;
    wr_valid_b = 1'b0; wr_data_b = '0; flush_b = 1'b0; step_b = 1'b1;

    // Reset held with a pending write
    repeat (3) begin
      tick();
      check_val("rst_wr_ready", 64'(wr_ready_a), 64'd0);
    end
    check_val("rst_in", 64'(in_a), 64'd0);
    check_val("rst_level", 64'(level_a), 64'd0);
    check_val("rst_busy", 64'(busy_a), 64'd0);
    check_val("rst_valid", 64'(instr_valid_a), 64'd0);
    check_val("rst_cnt", 64'(issued_a), 64'd0);
    reset = 1'b1; wr_valid_a = 1'b0;
    #1;
    check_val("rel_wr_ready", 64'(wr_ready_a), 64'd1);
    tick();

    // Single SW word, HOLD=5
    wr_valid_a = 1'b1; wr_data_a = 32'h1041_0000;
    tick();
    wr_valid_a = 1'b0;
    check_val("single_level_n1", 64'(level_a), 64'd1);
    check_val("single_in_n1", 64'(in_a), 64'd0);
    tick();
    check_val("single_in_n2", 64'(in_a), 64'h1041_0000);
    check_val("single_valid_n2", 64'(instr_valid_a), 64'd1);
    check_val("single_busy_n2", 64'(busy_a), 64'd1);
    check_val("single_cnt", 64'(issued_a), 64'd1);
    for (int i = 3; i <= 6; i++) begin
      tick();
      check_val("single_hold_in", 64'(in_a), 64'h1041_0000);
      check_val("single_hold_valid", 64'(instr_valid_a), 64'd0);
    end
    tick();
    check_val("single_in_n7", 64'(in_a), 64'd0);
    check_val("single_busy_n7", 64'(busy_a), 64'd0);

    // Overflow: 12 back-to-back words into a depth-8 FIFO draining every 5 cycles
    stalls = 0;
    for (int k = 1; k <= 12; k++) begin
      wr_valid_a = 1'b1; wr_data_a = 32'(k);
      guard = 0;
      while (!wr_ready_a && guard < 50) begin
        stalls++;
        check_val("ovf_full_level", 64'(level_a), 64'd8);
        tick();
        guard++;
      end
      tick();
    end
    wr_valid_a = 1'b0;
    check_val("ovf_stall_cycles", 64'(stalls), 64'd6);
    guard = 0;
    while ((level_a != 0 || busy_a) && guard < 200) begin tick(); guard++; end
    check_val("ovf_drained", 64'(guard < 200), 64'd1);
    check_val("ovf_cnt", 64'(issued_a), 64'd13);

    // Back-to-back issue on the HOLD=1 instance, then counter wrap (CNT_W=2)
    wr_valid_b = 1'b1; wr_data_b = 32'h0443_0800;
    tick();
    wr_data_b = 32'h1041_0000;
    tick();
    wr_data_b = 32'h0841_0000;
    check_val("b2b_in0", 64'(in_b), 64'h0443_0800);
    check_val("b2b_v0", 64'(instr_valid_b), 64'd1);
    tick();
    wr_valid_b = 1'b0;
    check_val("b2b_in1", 64'(in_b), 64'h1041_0000);
    check_val("b2b_v1", 64'(instr_valid_b), 64'd1);
    tick();
    check_val("b2b_in2", 64'(in_b), 64'h0841_0000);
    check_val("b2b_v2", 64'(instr_valid_b), 64'd1);
    check_val("b2b_cnt", 64'(issued_b), 64'd3);
    tick();
    check_val("b2b_in_end", 64'(in_b), 64'd0);
    check_val("b2b_v_end", 64'(instr_valid_b), 64'd0);
    wr_valid_b = 1'b1; wr_data_b = 32'h0000_0001;
    tick();
    wr_valid_b = 1'b0;
    tick();
    check_val("wrap_in", 64'(in_b), 64'd1);
    check_val("wrap_cnt", 64'(issued_b), 64'd0);

    // Flush during HOLD with three words queued; a push in the flush cycle is dropped
    for (int k = 0; k < 4; k++) begin
      wr_valid_a = 1'b1; wr_data_a = 32'hA1 + 32'(k);
      tick();
    end
    check_val("flush_pre_level", 64'(level_a), 64'd3);
    check_val("flush_pre_busy", 64'(busy_a), 64'd1);
    cnt_before = issued_a;
    flush_a = 1'b1; wr_data_a = 32'h0000_0BAD;
    tick();
    flush_a = 1'b0; wr_valid_a = 1'b0;
    check_val("flush_in", 64'(in_a), 64'd0);
    check_val("flush_level", 64'(level_a), 64'd0);
    check_val("flush_busy", 64'(busy_a), 64'd0);
    check_val("flush_valid", 64'(instr_valid_a), 64'd0);
    check_val("flush_cnt", 64'(issued_a), 64'(cnt_before));
    repeat (3) tick();
    check_val("flush_dropped_in", 64'(in_a), 64'd0);
    check_val("flush_dropped_level", 64'(level_a), 64'd0);

    // Reset in the middle of a hold
    wr_valid_a = 1'b1; wr_data_a = 32'h0000_0055;
    tick();
    wr_valid_a = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check_val("midrst_in", 64'(in_a), 64'd0);
    check_val("midrst_busy", 64'(busy_a), 64'd0);
    check_val("midrst_cnt", 64'(issued_a), 64'd0);
    check_val("midrst_level", 64'(level_a), 64'd0);
    reset = 1'b1;
    tick();

`ifdef INSTR_FEEDER_STEP_EN
    // Step gating: nothing issues until a step, one word per step
    step_a = 1'b0;
    wr_valid_a = 1'b1; wr_data_a = 32'h0000_0061;
    tick();
    wr_data_a = 32'h0000_0062;
    tick();
    wr_valid_a = 1'b0;
    repeat (20) tick();
    check_val("step_wait_in", 64'(in_a), 64'd0);
    check_val("step_wait_level", 64'(level_a), 64'd2);
    check_val("step_wait_cnt", 64'(issued_a), 64'd0);
    step_a = 1'b1;
    tick();
    step_a = 1'b0;
    check_val("step1_in", 64'(in_a), 64'h61);
    check_val("step1_level", 64'(level_a), 64'd1);
    repeat (10) tick();
    check_val("step1_after_in", 64'(in_a), 64'd0);
    check_val("step1_after_level", 64'(level_a), 64'd1);
    step_a = 1'b1;
    tick();
    check_val("step2_in", 64'(in_a), 64'h62);
    check_val("step2_level", 64'(level_a), 64'd0);
`else
    // Without the step feature, step=0 must not hold back issue
    step_a = 1'b0;
    wr_valid_a = 1'b1; wr_data_a = 32'h0000_0061;
    tick();
    wr_valid_a = 1'b0;
    tick();
    check_val("step_ignored_in", 64'(in_a), 64'h61);
    step_a = 1'b1;
`endif

    guard = 0;
    while ((level_a != 0 || busy_a) && guard < 200) begin tick(); guard++; end
    check_val("final_drained", 64'(guard < 200), 64'd1);
    repeat (2) tick();
    check_val("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
